// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-cycle sequencer for the program-counter stack.
//
// Runs the eight-state machine cycle (A1,A2,A3,M1,M2,X1,X2,X3 = 0..7) and captures
// OPR/OPA from the nibble bus. It decodes the PC-affecting instructions JUN, JMS, JCN,
// ISZ, JIN and BBL, and drives the PC stack's control, next-PC source select and nibble
// write enables. All outputs are registered.
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   data              instruction nibble bus (valid in M1/M2)
//   cond_true         JCN/ISZ jump condition, sampled at the end of X3 of the first word
//   regval            register-pair nibble; routed to the PC stack outside this block
//   cycle, sync       machine cycle 0..7; sync is high during cycle 7
//   opr, opa          first-word opcode and operand nibbles
//   second_word       this instruction cycle fetches the second word of a two-word op
//   fetch_discard     this instruction cycle is the dummy fetch that follows BBL
//   control           stack op NOP=0 PUSH=1 POP=2 (cycle 2 only)
//   pc_next_sel       next-PC nibble source DATA=0 REG=1 INST=2
//   pc_write_enable   one-hot PC nibble write: [0] PC[3:0], [1] PC[7:4], [2] PC[11:8]
//   inst_operand      a3 nibble latched from JUN/JMS
//   reg_half          1 selects the even (high) register of the pair
//   stack_overflow    sticky push-at-full flag
//   stack_underflow   sticky pop-at-empty flag
//
// Optional build macro PC_SEQ_HALT_EN adds halt (in) and halted (out): halt high during
// cycle 7 freezes the cycle counter at 7 with every enable low until halt falls.

module pc_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] data,
  input  logic       cond_true,
  input  logic [3:0] regval,
`ifdef PC_SEQ_HALT_EN
  input  logic       halt,
  output logic       halted,
`endif
  output logic [2:0] cycle,
  output logic       sync,
  output logic [3:0] opr,
  output logic [3:0] opa,
  output logic       second_word,
  output logic       fetch_discard,
  output logic [1:0] control,
  output logic [1:0] pc_next_sel,
  output logic [2:0] pc_write_enable,
  output logic [3:0] inst_operand,
  output logic       reg_half,
  output logic       stack_overflow,
  output logic       stack_underflow
);

  localparam int unsigned DepthW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DepthW-1:0] DepthMax = DepthW'(DEPTH - 1);

  localparam logic [1:0] CtlNop  = 2'd0;
  localparam logic [1:0] CtlPush = 2'd1;
  localparam logic [1:0] CtlPop  = 2'd2;

  localparam logic [1:0] SelData = 2'd0;
  localparam logic [1:0] SelReg  = 2'd1;
  localparam logic [1:0] SelInst = 2'd2;

  localparam logic [3:0] OpJcn = 4'h1;
  localparam logic [3:0] OpJin = 4'h3;
  localparam logic [3:0] OpJun = 4'h4;
  localparam logic [3:0] OpJms = 4'h5;
  localparam logic [3:0] OpIsz = 4'h7;
  localparam logic [3:0] OpBbl = 4'hC;

  typedef enum logic [2:0] {CycA1, CycA2, CycA3, CycM1, CycM2, CycX1, CycX2, CycX3} cycle_e;

  cycle_e            cycle_q, cycle_d;
  logic [3:0]        opr_q, opr_d, opa_q, opa_d;
  logic              second_word_q, second_word_d;
  logic              fetch_discard_q, fetch_discard_d;
  logic              sw_long_q, sw_long_d;   // pending second word belongs to JUN/JMS
  logic              sw_push_q, sw_push_d;   // pending second word belongs to JMS
  logic              taken_q, taken_d;
  logic [3:0]        inst_operand_q, inst_operand_d;
  logic [DepthW-1:0] depth_q, depth_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              sync_q, sync_d;
  logic [1:0]        control_q, control_d;
  logic [1:0]        sel_q, sel_d;
  logic [2:0]        we_q, we_d;
  logic              reg_half_q, reg_half_d;
  logic              halted_q, halted_d;

  logic advance, frozen, first_word, is_long, is_two, is_bbl;
  logic sw_jump, sw_cond, jin;

  // regval goes straight to the PC stack; only reg_half is generated here.
  logic unused_regval;
  assign unused_regval = ^regval;

  always_comb begin
    frozen  = 1'b0;
`ifdef PC_SEQ_HALT_EN
    frozen  = (cycle_q == CycX3) && halt;
`endif
    advance  = !frozen;
    halted_d = frozen;

    // Second-word and dummy-fetch cycles never decode and never reload OPR/OPA.
    first_word = !second_word_q && !fetch_discard_q;
    is_long    = first_word && (opr_q == OpJun || opr_q == OpJms);
    is_two     = is_long || (first_word && (opr_q == OpJcn || opr_q == OpIsz));
    is_bbl     = first_word && (opr_q == OpBbl);

    cycle_d = advance ? cycle_e'(cycle_q + 3'd1) : cycle_q;

    opr_d = opr_q;
    opa_d = opa_q;
    if (first_word && cycle_q == CycM1) opr_d = data;
    if (first_word && cycle_q == CycM2) opa_d = data;

    second_word_d   = second_word_q;
    fetch_discard_d = fetch_discard_q;
    sw_long_d       = sw_long_q;
    sw_push_d       = sw_push_q;
    taken_d         = taken_q;
    inst_operand_d  = inst_operand_q;
    if (advance && cycle_q == CycX3) begin
      second_word_d   = is_two;
      fetch_discard_d = is_bbl;
      sw_long_d       = is_long;
      sw_push_d       = first_word && (opr_q == OpJms);
      taken_d         = is_two && cond_true;
      if (is_long) inst_operand_d = opa_q;
    end

    // Depth moves at the end of cycle 2, when the stack performs the op.
    depth_d = depth_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (cycle_q == CycA3) begin
      if (control_q == CtlPush) begin
        if (depth_q == DepthMax) begin
          ovf_d   = 1'b1;
          depth_d = '0;
        end else begin
          depth_d = depth_q + DepthW'(1);
        end
      end else if (control_q == CtlPop) begin
        if (depth_q == '0) begin
          udf_d   = 1'b1;
          depth_d = DepthMax;
        end else begin
          depth_d = depth_q - DepthW'(1);
        end
      end
    end

    // Registered outputs are computed from the state the next cycle will hold.
    sw_jump = second_word_d && sw_long_d;
    sw_cond = second_word_d && !sw_long_d && taken_d;
    jin     = !second_word_d && !fetch_discard_d && (opr_d == OpJin) && opa_d[0];

    sync_d     = (cycle_d == CycX3) && !frozen;
    control_d  = CtlNop;
    sel_d      = SelData;
    we_d       = 3'b000;
    reg_half_d = 1'b0;
    if (!frozen) begin
      case (cycle_d)
        CycA3: begin
          if (second_word_d && sw_push_d) control_d = CtlPush;
          else if (fetch_discard_d)       control_d = CtlPop;
        end
        CycM1: if (sw_jump || sw_cond) we_d = 3'b010;
        CycM2: if (sw_jump || sw_cond) we_d = 3'b001;
        CycX1: begin
          if (sw_jump) begin
            sel_d = SelInst;
            we_d  = 3'b100;
          end
        end
        CycX2: begin
          if (jin) begin
            reg_half_d = 1'b1;
            sel_d      = SelReg;
            we_d       = 3'b010;
          end
        end
        CycX3: begin
          if (jin) begin
            sel_d = SelReg;
            we_d  = 3'b001;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q         <= CycA1;
      opr_q           <= 4'h0;
      opa_q           <= 4'h0;
      second_word_q   <= 1'b0;
      fetch_discard_q <= 1'b0;
      sw_long_q       <= 1'b0;
      sw_push_q       <= 1'b0;
      taken_q         <= 1'b0;
      inst_operand_q  <= 4'h0;
      depth_q         <= '0;
      ovf_q           <= 1'b0;
      udf_q           <= 1'b0;
      sync_q          <= 1'b0;
      control_q       <= CtlNop;
      sel_q           <= SelData;
      we_q            <= 3'b000;
      reg_half_q      <= 1'b0;
      halted_q        <= 1'b0;
    end else begin
      cycle_q         <= cycle_d;
      opr_q           <= opr_d;
      opa_q           <= opa_d;
      second_word_q   <= second_word_d;
      fetch_discard_q <= fetch_discard_d;
      sw_long_q       <= sw_long_d;
      sw_push_q       <= sw_push_d;
      taken_q         <= taken_d;
      inst_operand_q  <= inst_operand_d;
      depth_q         <= depth_d;
      ovf_q           <= ovf_d;
      udf_q           <= udf_d;
      sync_q          <= sync_d;
      control_q       <= control_d;
      sel_q           <= sel_d;
      we_q            <= we_d;
      reg_half_q      <= reg_half_d;
      halted_q        <= halted_d;
    end
  end

  assign cycle           = cycle_q;
  assign sync            = sync_q;
  assign opr             = opr_q;
  assign opa             = opa_q;
  assign second_word     = second_word_q;
  assign fetch_discard   = fetch_discard_q;
  assign control         = control_q;
  assign pc_next_sel     = sel_q;
  assign pc_write_enable = we_q;
  assign inst_operand    = inst_operand_q;
  assign reg_half        = reg_half_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = udf_q;
`ifdef PC_SEQ_HALT_EN
  assign halted          = halted_q;
`else
  logic unused_halted;
  assign unused_halted = halted_q;
`endif

endmodule
